// File: rtl/lcd_tim_pkg.sv
// Shared types for the LCD timing sequencer: phase encoding, the
// per-axis phase-length bundle and small helpers used by both axes.
package lcd_tim_pkg;

  // Field width of the phase-length bundle; the top-level C_WIDTH must match.
  localparam int unsigned LCD_CW = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    BACK  = 3'd2,
    ACT   = 3'd3,
    FRONT = 3'd4
  } phase_e;

  typedef struct packed {
    logic [LCD_CW-1:0] syncLen;
    logic [LCD_CW-1:0] backLen;
    logic [LCD_CW-1:0] actLen;
    logic [LCD_CW-1:0] frontLen;
  } phaseLens_t;

  // Final count of a phase; a zero length is treated as one count.
  function automatic logic [LCD_CW-1:0] lastCount(input logic [LCD_CW-1:0] len);
    if (len == {LCD_CW{1'b0}}) begin
      return {LCD_CW{1'b0}};
    end else begin
      return len - {{(LCD_CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Fixed phase order; IDLE is only left through the explicit start path.
  function automatic phase_e nextPhase(input phase_e ph);
    case (ph)
      SYNC:    return BACK;
      BACK:    return ACT;
      ACT:     return FRONT;
      FRONT:   return SYNC;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_sequencer_phase.sv
// One axis of the timing generator: a phase FSM with a count inside the
// current phase. Exposes the next state so the owner can register its
// outputs without adding latency, and a wrap pulse that fires when the
// axis leaves IDLE or completes its FRONT phase.
module lcd_phase_seq
  import lcd_tim_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iAdvance,
  input  phaseLens_t        iLens,
  output phase_e            phase,
  output logic [LCD_CW-1:0] count,
  output phase_e            phaseNext,
  output logic [LCD_CW-1:0] countNext,
  output logic              wrap
);

  logic [LCD_CW-1:0] lenSel_s;
  logic              atLast_s;

  // Next-state decode: step the count, roll into the next phase on the last count.
  always_comb begin
    case (phase)
      SYNC:    lenSel_s = iLens.syncLen;
      BACK:    lenSel_s = iLens.backLen;
      ACT:     lenSel_s = iLens.actLen;
      FRONT:   lenSel_s = iLens.frontLen;
      default: lenSel_s = {LCD_CW{1'b0}};
    endcase
    atLast_s  = (count == lastCount(lenSel_s));
    phaseNext = phase;
    countNext = count;
    wrap      = 1'b0;
    if (iAdvance) begin
      case (phase)
        IDLE: begin
          phaseNext = SYNC;
          countNext = {LCD_CW{1'b0}};
          wrap      = 1'b1;
        end
        SYNC, BACK, ACT, FRONT: begin
          if (atLast_s) begin
            phaseNext = nextPhase(phase);
            countNext = {LCD_CW{1'b0}};
            wrap      = (phase == FRONT);
          end else begin
            countNext = count + {{(LCD_CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          phaseNext = IDLE;
          countNext = {LCD_CW{1'b0}};
        end
      endcase
    end else begin
      phaseNext = phase;
      countNext = count;
    end
  end

  // Phase and count state registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      phase <= IDLE;
      count <= {LCD_CW{1'b0}};
    end else begin
      phase <= phaseNext;
      count <= countNext;
    end
  end

endmodule

// File: rtl/lcd_timing_sequencer.sv
// LCD frame timing: horizontal axis steps every enabled pixel clock, the
// vertical axis steps once per completed line. Timing lengths live in an
// active shadow that only changes at a frame boundary, so a reprogram
// through iCfgLoad never tears a frame.
module lcd_timing_sequencer
  import lcd_tim_pkg::*;
#(
  parameter int unsigned C_WIDTH     = LCD_CW,
  parameter bit          C_HSYNC_POL = 1'b0,
  parameter bit          C_VSYNC_POL = 1'b0
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic [C_WIDTH-1:0] iHSyncLen,
  input  logic [C_WIDTH-1:0] iHBackLen,
  input  logic [C_WIDTH-1:0] iHActLen,
  input  logic [C_WIDTH-1:0] iHFrontLen,
  input  logic [C_WIDTH-1:0] iVSyncLen,
  input  logic [C_WIDTH-1:0] iVBackLen,
  input  logic [C_WIDTH-1:0] iVActLen,
  input  logic [C_WIDTH-1:0] iVFrontLen,
  input  logic               iCfgLoad,
  output logic               oCfgPending,
  output logic               oHSync,
  output logic               oVSync,
  output logic               oDe,
  output logic [C_WIDTH-1:0] oX,
  output logic [C_WIDTH-1:0] oY,
  output logic               oLineStart,
  output logic               oFrameStart
);

  phaseLens_t        hIn_s, vIn_s;
  phaseLens_t        hAct_r, vAct_r, hPend_r, vPend_r;
  phase_e            hPhase_s, vPhase_s, hPhaseNext_s, vPhaseNext_s;
  logic [LCD_CW-1:0] hCount_s, vCount_s, hCountNext_s, vCountNext_s;
  logic              hWrap_s, vWrap_s, deNext_s;

  assign hIn_s = '{syncLen: iHSyncLen, backLen: iHBackLen, actLen: iHActLen, frontLen: iHFrontLen};
  assign vIn_s = '{syncLen: iVSyncLen, backLen: iVBackLen, actLen: iVActLen, frontLen: iVFrontLen};

  lcd_phase_seq uHSeq (
    .iClk      (iClk),
    .iRst      (iRst),
    .iAdvance  (iEn),
    .iLens     (hAct_r),
    .phase     (hPhase_s),
    .count     (hCount_s),
    .phaseNext (hPhaseNext_s),
    .countNext (hCountNext_s),
    .wrap      (hWrap_s)
  );

  lcd_phase_seq uVSeq (
    .iClk      (iClk),
    .iRst      (iRst),
    .iAdvance  (hWrap_s),
    .iLens     (vAct_r),
    .phase     (vPhase_s),
    .count     (vCount_s),
    .phaseNext (vPhaseNext_s),
    .countNext (vCountNext_s),
    .wrap      (vWrap_s)
  );

  assign deNext_s = (hPhaseNext_s == ACT) && (vPhaseNext_s == ACT);

  // Pending capture and frame-boundary promotion of the timing configuration.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hAct_r      <= hIn_s;
      vAct_r      <= vIn_s;
      hPend_r     <= '0;
      vPend_r     <= '0;
      oCfgPending <= 1'b0;
    end else begin
      if (vWrap_s && oCfgPending) begin
        hAct_r <= hPend_r;
        vAct_r <= vPend_r;
      end
      if (iCfgLoad) begin
        hPend_r     <= hIn_s;
        vPend_r     <= vIn_s;
        oCfgPending <= 1'b1;
      end else if (vWrap_s) begin
        oCfgPending <= 1'b0;
      end
    end
  end

  // Output register, decoded from next state so it lines up with the state registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oHSync      <= ~C_HSYNC_POL;
      oVSync      <= ~C_VSYNC_POL;
      oDe         <= 1'b0;
      oX          <= {C_WIDTH{1'b0}};
      oY          <= {C_WIDTH{1'b0}};
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oHSync      <= (hPhaseNext_s == SYNC) ? C_HSYNC_POL : ~C_HSYNC_POL;
      oVSync      <= (vPhaseNext_s == SYNC) ? C_VSYNC_POL : ~C_VSYNC_POL;
      oDe         <= deNext_s;
      oX          <= deNext_s ? hCountNext_s : {C_WIDTH{1'b0}};
      oY          <= deNext_s ? vCountNext_s : {C_WIDTH{1'b0}};
      oLineStart  <= hWrap_s;
      oFrameStart <= vWrap_s;
    end
  end

endmodule
